rcg_ctrl_div_seq: RTL and testbench
===================================

// Module: rcg_ctrl_div_seq
// PURPOSE
//  Sequencer for a group of NUM_DIV rcg_ctrl_div_cntr instances sharing clk_in.
//  Accepts a new ratio set over a 4-phase req/ack handshake, waits for all
//  dividers to align, holds them in alignment reset, loads the ratios atomically,
//  then releases them with a single go pulse so all derived clocks restart phase-locked.
// PARAMETERS
//  NUM_DIV     4    number of controlled dividers (1..16)
//  DIV_WIDTH   16   ratio width per divider
//  INIT_RATIO  1    ratio driven to every lane after reset (1 = bypass)
//  HOLD_CYC    2    cycles div_aln_rst_n is held low (>=1)
//  TO_CYC      1024 WAIT_ALIGN timeout in clk_in cycles (>=2)
// PORTS
//  clk_in         in   1                  source clock of all dividers
//  grst_n         in   1                  async active-low reset
//  cfg_req        in   1                  ratio-change request, level, 4-phase
//  cfg_ratio      in   NUM_DIV*DIV_WIDTH  new ratios, lane i at [i*DIV_WIDTH +: DIV_WIDTH]
//  div_clk_align  in   NUM_DIV            per-divider align indication
//  cfg_ack        out  1                  request done; held until cfg_req low
//  cfg_busy       out  1                  sequence in progress (not IDLE)
//  timeout_err    out  1                  sticky: alignment wait timed out
//  div_ratio      out  NUM_DIV*DIV_WIDTH  ratios to dividers, lane packing as cfg_ratio
//  div_aln_rst_n  out  1                  common alignment reset, active low
//  divider_go_pls out  1                  common restart pulse, one cycle
// BEHAVIOUR
//  Reset: reset grst_n, asynchronous, active-low; clock clk_in. All outputs registered.
//   state=IDLE, cfg_ack=0, cfg_busy=0, timeout_err=0, div_aln_rst_n=1,
//   divider_go_pls=0, every div_ratio lane=INIT_RATIO, shadow ratios=INIT_RATIO.
//  FSM (one transition per clk_in rising edge):
//   IDLE: cfg_req=1 -> capture cfg_ratio into shadow, clear timeout_err, clear
//     timeout counter -> WAIT_ALIGN. cfg_ratio is don't-care after capture.
//   WAIT_ALIGN: &div_clk_align=1 -> HOLD. Otherwise count; count reaching
//     TO_CYC-1 -> set timeout_err, -> HOLD anyway (forced realignment).
//   HOLD: div_aln_rst_n=0 for exactly HOLD_CYC cycles; div_ratio<=shadow on the
//     edge entering HOLD (all lanes same edge). After HOLD_CYC cycles -> GO.
//   GO: divider_go_pls=1 and div_aln_rst_n=1 for exactly one cycle -> ACK.
//   ACK: cfg_ack=1; cfg_req=0 -> IDLE (cfg_ack=0 from that edge on).
//  cfg_busy=1 in every state except IDLE; cfg_ack=1 only in ACK.
//  Latency, aligned dividers, HOLD_CYC=2: req seen at edge k -> busy at k+1,
//   aln_rst_n low k+2..k+3, go pulse k+4, ack from k+5.
//  Boundaries:
//   - cfg_req dropped before ACK: sequence still completes; ACK lasts one cycle.
//   - cfg_req high in IDLE right after ACK exits: new request accepted (back-to-back).
//   - New ratios equal to current: full sequence still executed.
//   - Ratio lanes of 0/1 (bypass) load unchanged; dividers report align=1.
//   - div_clk_align glitching only in non-WAIT_ALIGN states: ignored.
//   - grst_n low in any state: immediate return to reset values, shadow lost.
//   - Timeout counter width clog2(TO_CYC); no wrap (saturates via transition).
// TESTING
//  1 Reset: grst_n low mid-HOLD -> div_aln_rst_n=1, busy=0, all div_ratio=INIT_RATIO.
//  2 NUM_DIV=4, align all 1, req lanes {8,4,2,1} -> ratio update k+2, aln_rst_n
//    low 2 cycles, go_pls 1 cycle at k+4, ack k+5, timeout_err=0.
//  3 align=4'b0111 constant, TO_CYC=16 -> timeout_err=1 after 16 cycles in
//    WAIT_ALIGN, HOLD/GO still issued, ack asserted; next req clears timeout_err.
//  4 align lane3 rises 10 cycles late -> HOLD entered edge after &align=1, not before.
//  5 req dropped at k+2 -> ack high exactly one cycle at k+5, then IDLE.
//  6 back-to-back: req held, dropped 1 cycle after ack, raised next cycle with new
//    ratios -> second sequence loads new values; no go pulse outside GO state.

Source files
------------

// File: rtl/rcg_ctrl_div_seq_if.sv
// Config handshake and divider control bundle between the ratio sequencer and its
// requester/divider group. slave = sequencer side, master = requester/divider side.
interface rcg_ctrl_div_seq_if #(
    parameter int NUM_DIV   = 4,
    parameter int DIV_WIDTH = 16
);
    logic                           cfg_req;
    logic [NUM_DIV*DIV_WIDTH-1:0]   cfg_ratio;
    logic [NUM_DIV-1:0]             div_clk_align;
    logic                           cfg_ack;
    logic                           cfg_busy;
    logic                           timeout_err;
    logic [NUM_DIV*DIV_WIDTH-1:0]   div_ratio;
    logic                           div_aln_rst_n;
    logic                           divider_go_pls;

    modport master (
        output cfg_req, cfg_ratio, div_clk_align,
        input  cfg_ack, cfg_busy, timeout_err, div_ratio, div_aln_rst_n, divider_go_pls
    );

    modport slave (
        input  cfg_req, cfg_ratio, div_clk_align,
        output cfg_ack, cfg_busy, timeout_err, div_ratio, div_aln_rst_n, divider_go_pls
    );
endinterface

// File: rtl/rcg_ctrl_div_seq.sv
// Ratio-change sequencer: captures a ratio set, waits for divider alignment, holds the
// dividers in alignment reset while loading ratios, then restarts them with one go pulse.
module rcg_ctrl_div_seq #(
    parameter int NUM_DIV    = 4,
    parameter int DIV_WIDTH  = 16,
    parameter int INIT_RATIO = 1,
    parameter int HOLD_CYC   = 2,
    parameter int TO_CYC     = 1024
) (
    input  logic              clk_in,
    input  logic              grst_n,
    rcg_ctrl_div_seq_if.slave bus
);
    // state      | meaning
    // IDLE       | waiting for cfg_req
    // WAIT_ALIGN | waiting for all dividers aligned, or timeout
    // HOLD       | alignment reset asserted, new ratios applied
    // GO         | one-cycle restart pulse
    // ACK        | cfg_ack high until cfg_req drops

    localparam int RW     = NUM_DIV * DIV_WIDTH;
    localparam int TO_W   = $clog2(TO_CYC);
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [RW-1:0] INIT_VEC = {NUM_DIV{DIV_WIDTH'(INIT_RATIO)}};

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ALIGN,
        HOLD,
        GO,
        ACK
    } state_t;

    state_t            state;
    logic [RW-1:0]     shadow;
    logic [RW-1:0]     ratio_q;
    logic [TO_W-1:0]   to_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              ack_q;
    logic              busy_q;
    logic              timeout_q;
    logic              aln_rst_n_q;
    logic              go_q;
    logic              all_aligned;

    assign all_aligned = &bus.div_clk_align;

    always_ff @(posedge clk_in or negedge grst_n) begin
        if (!grst_n) begin
            state       <= IDLE;
            shadow      <= INIT_VEC;
            ratio_q     <= INIT_VEC;
            to_cnt      <= '0;
            hold_cnt    <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            aln_rst_n_q <= 1'b1;
            go_q        <= 1'b0;
        end else begin
            go_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cfg_req) begin
                        shadow    <= bus.cfg_ratio;
                        timeout_q <= 1'b0;
                        to_cnt    <= TO_W'(TO_CYC - 1);
                        busy_q    <= 1'b1;
                        state     <= WAIT_ALIGN;
                    end
                end
                WAIT_ALIGN: begin
                    // Timeout still forces a realignment so the group never stays stuck.
                    if (all_aligned || to_cnt == '0) begin
                        if (!all_aligned) begin
                            timeout_q <= 1'b1;
                        end
                        ratio_q     <= shadow;
                        aln_rst_n_q <= 1'b0;
                        hold_cnt    <= HOLD_W'(HOLD_CYC - 1);
                        state       <= HOLD;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        aln_rst_n_q <= 1'b1;
                        go_q        <= 1'b1;
                        state       <= GO;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                GO: begin
                    ack_q <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    if (!bus.cfg_req) begin
                        ack_q  <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    ack_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    aln_rst_n_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ack        = ack_q;
    assign bus.cfg_busy       = busy_q;
    assign bus.timeout_err    = timeout_q;
    assign bus.div_ratio      = ratio_q;
    assign bus.div_aln_rst_n  = aln_rst_n_q;
    assign bus.divider_go_pls = go_q;
endmodule

// File: tb/tb_rcg_ctrl_div_seq.sv
// Bench for rcg_ctrl_div_seq: directed table plus randomized transactions, each checked
// cycle by cycle against an event-schedule model of the ratio-change sequence.
module tb_rcg_ctrl_div_seq;
    localparam int NDIV = 4;
    localparam int DW   = 16;
    localparam int H    = 2;
    localparam int TO   = 16;
    localparam logic [63:0] INIT_VEC = 64'h0001_0001_0001_0001;

    typedef struct {
        logic [63:0] ratio;
        int          late;     // first WAIT_ALIGN edge index at which align is all ones
        logic [3:0]  base;     // align pattern before that
        int          drop;     // first edge index at which cfg_req is low
        int          gap;      // idle cycles before the request
        int          exp_jh;   // expected edge index entering HOLD
        bit          exp_to;   // expected timeout_err
    } vec_t;

    logic clk_in = 1'b0;
    logic grst_n = 1'b0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    logic [63:0] cur_ratio = INIT_VEC;
    bit          cur_to    = 1'b0;

    rcg_ctrl_div_seq_if #(.NUM_DIV(NDIV), .DIV_WIDTH(DW)) bus ();

    rcg_ctrl_div_seq #(
        .NUM_DIV(NDIV), .DIV_WIDTH(DW), .INIT_RATIO(1), .HOLD_CYC(H), .TO_CYC(TO)
    ) dut (
        .clk_in (clk_in),
        .grst_n (grst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [68:0] pack(input bit busy, input bit ack, input bit aln,
                                         input bit go, input bit to, input logic [63:0] r);
        return {busy, ack, aln, go, to, r};
    endfunction

    task automatic chk(input string name, input logic [68:0] expv);
        logic [68:0] act;
        act = {bus.cfg_busy, bus.cfg_ack, bus.div_aln_rst_n, bus.divider_go_pls,
               bus.timeout_err, bus.div_ratio};
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got {busy,ack,aln_n,go,to,ratio}=%h, expected %h", name, act, expv);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int g = 0; g < n; g++) begin
            bus.cfg_req       = 1'b0;
            bus.cfg_ratio     = {$urandom, $urandom};
            bus.div_clk_align = 4'($urandom);
            @(negedge clk_in);
            chk($sformatf("%s idle%0d", tag, g), pack(0, 0, 1, 0, cur_to, cur_ratio));
        end
    endtask

    // Expected outputs follow from three event times: hold entry jh, ack entry, and the
    // exit edge ex = max(first ack-state edge, request drop edge).
    task automatic run_txn(input string tag, input logic [63:0] r, input int late,
                           input logic [3:0] base, input bit rnd_base, input int d,
                           input int gap, input bit use_tab, input int tab_jh,
                           input bit tab_to);
        logic [3:0] al [1:TO];
        int jh, ea, ex;
        bit tf;
        idle_cycles(gap, tag);
        for (int j = 1; j <= TO; j++)
            al[j] = (j >= late) ? 4'hF : (rnd_base ? 4'($urandom_range(0, 14)) : base);
        jh = TO;
        tf = 1'b1;
        for (int j = TO; j >= 1; j--)
            if (al[j] == 4'hF) begin jh = j; tf = 1'b0; end
        if (use_tab) begin
            jh = tab_jh;
            tf = tab_to;
        end
        ea = jh + H + 2;
        ex = (d > ea) ? d : ea;
        for (int e = 0; e <= ex; e++) begin
            bus.cfg_req       = (e < d);
            bus.cfg_ratio     = (e == 0) ? r : {$urandom, $urandom};
            bus.div_clk_align = (e >= 1 && e <= jh) ? al[e] : 4'($urandom);
            @(negedge clk_in);
            chk($sformatf("%s e=%0d", tag, e),
                pack(e < ex,
                     (e >= jh + H + 1) && (e < ex),
                     !((e >= jh) && (e < jh + H)),
                     e == jh + H,
                     (e >= jh) ? tf : 1'b0,
                     (e >= jh) ? r : cur_ratio));
        end
        cur_ratio = r;
        cur_to    = tf;
    endtask

    vec_t tab [7];

    initial begin
        tab[0] = '{64'h0008_0004_0002_0001, 1,  4'h7, 8,  2, 1,  1'b0};  // basic latency
        tab[1] = '{64'h0008_0004_0002_0001, 1,  4'h7, 2,  1, 1,  1'b0};  // same ratios, early drop
        tab[2] = '{64'h0001_0000_0001_0000, 99, 4'h7, 20, 1, 16, 1'b1};  // never aligns
        tab[3] = '{64'h00FF_0010_0003_0007, 11, 4'h7, 3,  0, 11, 1'b0};  // lane3 late
        tab[4] = '{64'h1234_5678_9ABC_DEF0, 1,  4'h3, 5,  2, 1,  1'b0};  // drop right after ack
        tab[5] = '{64'h0005_0006_0007_0009, 2,  4'hE, 9,  0, 2,  1'b0};  // back-to-back
        tab[6] = '{64'h0000_0001_0000_0001, 3,  4'h0, 7,  3, 3,  1'b0};  // bypass lanes

        bus.cfg_req       = 1'b0;
        bus.cfg_ratio     = '0;
        bus.div_clk_align = 4'hF;
        repeat (3) @(negedge clk_in);
        chk("reset", pack(0, 0, 1, 0, 0, INIT_VEC));
        grst_n = 1'b1;
        idle_cycles(2, "post_reset");

        // Reset asserted mid-HOLD must return everything to reset values immediately.
        bus.cfg_ratio     = 64'h0003_0003_0003_0003;
        bus.cfg_req       = 1'b1;
        bus.div_clk_align = 4'hF;
        @(negedge clk_in);
        chk("rst_seq busy", pack(1, 0, 1, 0, 0, INIT_VEC));
        @(negedge clk_in);
        chk("rst_seq hold", pack(1, 0, 0, 0, 0, 64'h0003_0003_0003_0003));
        #3 grst_n = 1'b0;
        #1 chk("rst_seq async", pack(0, 0, 1, 0, 0, INIT_VEC));
        bus.cfg_req = 1'b0;
        repeat (2) @(negedge clk_in);
        grst_n    = 1'b1;
        cur_ratio = INIT_VEC;
        cur_to    = 1'b0;
        idle_cycles(2, "rst_seq after");

        for (int i = 0; i < 7; i++)
            run_txn($sformatf("tab%0d", i), tab[i].ratio, tab[i].late, tab[i].base, 1'b0,
                    tab[i].drop, tab[i].gap, 1'b1, tab[i].exp_jh, tab[i].exp_to);

        for (int i = 0; i < 25; i++)
            run_txn($sformatf("rnd%0d", i), {$urandom, $urandom}, $urandom_range(1, 20),
                    4'h0, 1'b1, $urandom_range(1, 30), $urandom_range(0, 3), 1'b0, 0, 1'b0);

        idle_cycles(2, "final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
